// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared types and helpers for the cim_row_sched column sequencer.
package cim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_DRAIN,
    ST_OUT
  } state_t;

  localparam logic MODE_LOAD    = 1'b0;
  localparam logic MODE_COMPUTE = 1'b1;

  // Product width of two cell words once the metadata LSB is stripped from each.
  function automatic int prod_w(input int data_width);
    return 2 * (data_width - 1);
  endfunction

endpackage

// File: rtl/cim_col_acc.sv
// rtl/cim_col_acc.sv - column-sum accumulator and received-result counter.
// CIM_ROW_SCHED_SAT_EN selects a saturating sum with a sticky acc_sat flag; default wraps.
module cim_col_acc #(
  parameter int PROD_W    = 16,
  parameter int ACC_WIDTH = 24,
  parameter int ROW_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clear,
  input  logic                 i_add,
  input  logic [PROD_W-1:0]    i_value,
  output logic [ACC_WIDTH-1:0] o_acc,
`ifdef CIM_ROW_SCHED_SAT_EN
  output logic                 o_sat,
`endif
  output logic [ROW_W-1:0]     o_received_next
);

  logic [ACC_WIDTH-1:0] r_acc;
  logic [ROW_W-1:0]     r_received;

  // The scheduler compares against the post-add count so a result landing on the check cycle counts.
  assign o_received_next = i_add ? (r_received + ROW_W'(1)) : r_received;
  assign o_acc           = r_acc;

`ifdef CIM_ROW_SCHED_SAT_EN
  logic                 r_sat;
  logic [ACC_WIDTH:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + (ACC_WIDTH + 1)'(i_value);
  assign o_sat = r_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_received <= '0;
      r_sat      <= 1'b0;
    end else if (i_clear) begin
      r_acc      <= '0;
      r_received <= '0;
      r_sat      <= 1'b0;
    end else if (i_add) begin
      r_received <= r_received + ROW_W'(1);
      if (w_sum[ACC_WIDTH]) begin
        r_acc <= '1;
        r_sat <= 1'b1;
      end else begin
        r_acc <= w_sum[ACC_WIDTH-1:0];
      end
    end
  end
`else
  logic [ACC_WIDTH-1:0] w_sum;

  assign w_sum = r_acc + ACC_WIDTH'(i_value);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_received <= '0;
    end else if (i_clear) begin
      r_acc      <= '0;
      r_received <= '0;
    end else if (i_add) begin
      r_received <= r_received + ROW_W'(1);
      r_acc      <= w_sum;
    end
  end
`endif

endmodule

// File: rtl/cim_row_sched.sv
// rtl/cim_row_sched.sv - LOAD/COMPUTE sequencer for one column of cim_cell rows.
// Macro CIM_ROW_SCHED_SAT_EN adds a saturating accumulator and the acc_sat output.
module cim_row_sched
  import cim_pkg::*;
#(
  parameter int  DATA_WIDTH = 9,
  parameter int  NUM_ROWS   = 16,
  parameter int  ACC_WIDTH  = 24,
  localparam int ROW_W      = $clog2(NUM_ROWS + 1),
  localparam int PROD_W     = prod_w(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_start,
  input  logic                  cmd_mode,
  input  logic [ROW_W-1:0]      cmd_rows,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [DATA_WIDTH-1:0] a_data_n,
  output logic [NUM_ROWS-1:0]   cell_en,
  output logic [NUM_ROWS-1:0]   cell_write_en,
  output logic [NUM_ROWS-1:0]   cell_sel,
  output logic [DATA_WIDTH-1:0] data_line,
  output logic [DATA_WIDTH-1:0] data_line_n,
  input  logic                  cell_valid,
  input  logic [PROD_W-1:0]     cell_result,
  output logic                  acc_valid,
  input  logic                  acc_ready,
  output logic [ACC_WIDTH-1:0]  acc_data,
`ifdef CIM_ROW_SCHED_SAT_EN
  output logic                  acc_sat,
`endif
  output logic                  busy,
  output logic                  done
);

  state_t                r_state;
  logic [ROW_W-1:0]      r_n;
  logic [ROW_W-1:0]      r_row;
  logic                  r_w_ready;
  logic                  r_a_ready;
  logic                  r_acc_valid;
  logic                  r_done;
  logic                  r_done_pend;
  logic [NUM_ROWS-1:0]   r_cell_en;
  logic [NUM_ROWS-1:0]   r_cell_write_en;
  logic [NUM_ROWS-1:0]   r_cell_sel;
  logic [DATA_WIDTH-1:0] r_data_line;
  logic [DATA_WIDTH-1:0] r_data_line_n;

  logic [ROW_W-1:0]      w_n_req;
  logic [ROW_W-1:0]      w_received_next;
  logic [NUM_ROWS-1:0]   w_row_onehot;
  logic                  w_w_fire;
  logic                  w_a_fire;
  logic                  w_last_beat;
  logic                  w_clear;
  logic                  w_add;

  assign w_n_req      = (cmd_rows > ROW_W'(NUM_ROWS)) ? ROW_W'(NUM_ROWS) : cmd_rows;
  assign w_row_onehot = NUM_ROWS'(1) << r_row;
  assign w_w_fire     = w_valid && r_w_ready;
  assign w_a_fire     = a_valid && r_a_ready;
  assign w_last_beat  = (r_row + ROW_W'(1)) == r_n;
  assign w_clear      = (r_state == ST_IDLE) && cmd_start;
  assign w_add        = cell_valid && ((r_state == ST_COMPUTE) || (r_state == ST_DRAIN));

  assign w_ready       = r_w_ready;
  assign a_ready       = r_a_ready;
  assign acc_valid     = r_acc_valid;
  assign cell_en       = r_cell_en;
  assign cell_write_en = r_cell_write_en;
  assign cell_sel      = r_cell_sel;
  assign data_line     = r_data_line;
  assign data_line_n   = r_data_line_n;
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;

  cim_col_acc #(
    .PROD_W    (PROD_W),
    .ACC_WIDTH (ACC_WIDTH),
    .ROW_W     (ROW_W)
  ) u_col_acc (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_clear         (w_clear),
    .i_add           (w_add),
    .i_value         (cell_result),
    .o_acc           (acc_data),
`ifdef CIM_ROW_SCHED_SAT_EN
    .o_sat           (acc_sat),
`endif
    .o_received_next (w_received_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_n             <= '0;
      r_row           <= '0;
      r_w_ready       <= 1'b0;
      r_a_ready       <= 1'b0;
      r_acc_valid     <= 1'b0;
      r_done          <= 1'b0;
      r_done_pend     <= 1'b0;
      r_cell_en       <= '0;
      r_cell_write_en <= '0;
      r_cell_sel      <= '0;
      r_data_line     <= '0;
      r_data_line_n   <= '0;
    end else begin
      r_cell_en       <= '0;
      r_cell_write_en <= '0;
      r_cell_sel      <= '0;
      // A finished LOAD reports done one cycle after its last write strobe.
      r_done          <= r_done_pend;
      r_done_pend     <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (cmd_start) begin
            r_n   <= w_n_req;
            r_row <= '0;
            if (cmd_mode == MODE_LOAD) begin
              if (w_n_req == '0) begin
                r_done <= 1'b1;
              end else begin
                r_state   <= ST_LOAD;
                r_w_ready <= 1'b1;
              end
            end else begin
              if (w_n_req == '0) begin
                r_state     <= ST_OUT;
                r_acc_valid <= 1'b1;
              end else begin
                r_state   <= ST_COMPUTE;
                r_a_ready <= 1'b1;
              end
            end
          end
        end

        ST_LOAD: begin
          if (w_w_fire) begin
            r_cell_en       <= w_row_onehot;
            r_cell_write_en <= w_row_onehot;
            r_data_line     <= w_data;
            r_data_line_n   <= '0;
            r_row           <= r_row + ROW_W'(1);
            if (w_last_beat) begin
              r_w_ready   <= 1'b0;
              r_state     <= ST_IDLE;
              r_done_pend <= 1'b1;
            end
          end
        end

        ST_COMPUTE: begin
          if (w_a_fire) begin
            r_cell_en     <= w_row_onehot;
            r_cell_sel    <= w_row_onehot;
            r_data_line   <= a_data;
            r_data_line_n <= a_data_n;
            r_row         <= r_row + ROW_W'(1);
            if (w_last_beat) begin
              r_a_ready <= 1'b0;
              r_state   <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          if (w_received_next == r_n) begin
            r_state     <= ST_OUT;
            r_acc_valid <= 1'b1;
          end
        end

        ST_OUT: begin
          if (acc_ready) begin
            r_acc_valid <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cim_row_sched.sv
// tb/tb_cim_row_sched.sv - scoreboard bench for cim_row_sched with a behavioural cell column.
module tb_cim_row_sched;
  import cim_pkg::*;

  localparam int DW    = 9;
  localparam int NR    = 16;
  localparam int AW    = 16;
  localparam int ROW_W = $clog2(NR + 1);
  localparam int PW    = 2 * (DW - 1);
  localparam longint ACC_MAX = (64'd1 << AW) - 1;

  typedef struct packed {
    logic [NR-1:0] en;
    logic [NR-1:0] we;
    logic [NR-1:0] sel;
    logic [DW-1:0] dl;
    logic [DW-1:0] dln;
  } strobe_t;

  typedef struct packed {
    logic [AW-1:0] data;
    logic          sat;
  } acc_exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_start, cmd_mode;
  logic [ROW_W-1:0] cmd_rows;
  logic             w_valid, w_ready, a_valid, a_ready;
  logic [DW-1:0]    w_data, a_data, a_data_n, data_line, data_line_n;
  logic [NR-1:0]    cell_en, cell_write_en, cell_sel;
  logic             cell_valid;
  logic [PW-1:0]    cell_result;
  logic             acc_valid, acc_ready, busy, done;
  logic [AW-1:0]    acc_data;
`ifdef CIM_ROW_SCHED_SAT_EN
  logic             acc_sat;
`endif

  int vec  = 0;
  int errs = 0;

  strobe_t  sb_strobe[$];
  acc_exp_t sb_acc[$];
  logic [DW-1:0] stim_w[NR], stim_a[NR], stim_an[NR], ref_w[NR];
  logic [DW-1:0] cell_mem[NR];

  always #5 clk = ~clk;

  cim_row_sched #(.DATA_WIDTH(DW), .NUM_ROWS(NR), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_mode(cmd_mode), .cmd_rows(cmd_rows),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_data_n(a_data_n),
    .cell_en(cell_en), .cell_write_en(cell_write_en), .cell_sel(cell_sel),
    .data_line(data_line), .data_line_n(data_line_n),
    .cell_valid(cell_valid), .cell_result(cell_result),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
`ifdef CIM_ROW_SCHED_SAT_EN
    .acc_sat(acc_sat),
`endif
    .busy(busy), .done(done)
  );

  // Cell column: stores on write strobe, returns a registered product one cycle after sel.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cell_valid  <= 1'b0;
      cell_result <= '0;
    end else begin
      cell_valid  <= 1'b0;
      cell_result <= '0;
      for (int r = 0; r < NR; r++) begin
        if (cell_en[r]) begin
          if (cell_write_en[r]) cell_mem[r] <= data_line;
          if (cell_sel[r]) begin
            cell_valid  <= 1'b1;
            cell_result <= PW'(cell_mem[r][DW-1:1]) *
                           PW'(cell_mem[r][0] ? data_line_n[DW-1:1] : data_line[DW-1:1]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    strobe_t e;
    if (rst_n && ((cell_en != '0) || (cell_write_en != '0) || (cell_sel != '0))) begin
      if (sb_strobe.size() == 0) begin
        vec++; errs++;
        $display("FAIL unexpected_strobe: got en=%h we=%h sel=%h, expected none", cell_en, cell_write_en, cell_sel);
      end else begin
        e = sb_strobe.pop_front();
        check("strobe_en", cell_en, e.en);
        check("strobe_we", cell_write_en, e.we);
        check("strobe_sel", cell_sel, e.sel);
        check("strobe_line", data_line, e.dl);
        check("strobe_line_n", data_line_n, e.dln);
      end
    end
  end

  logic          have_cur = 1'b0;
  logic [AW-1:0] cur_acc;
  always @(negedge clk) begin
    acc_exp_t x;
    if (rst_n && acc_valid) begin
      if (!have_cur) begin
        if (sb_acc.size() == 0) begin
          vec++; errs++;
          $display("FAIL unexpected_acc: got 0x%0h, expected no output", acc_data);
        end else begin
          x = sb_acc.pop_front();
          check("acc_data", acc_data, x.data);
`ifdef CIM_ROW_SCHED_SAT_EN
          check("acc_sat", acc_sat, x.sat);
`endif
          cur_acc  = acc_data;
          have_cur = 1'b1;
        end
      end else begin
        check("acc_stable", acc_data, cur_acc);
      end
      if (acc_ready) have_cur = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_cmd(input logic mode, input int rows);
    cmd_start = 1'b1; cmd_mode = mode; cmd_rows = ROW_W'(rows);
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic w_beat(input int row, output bit ok);
    strobe_t e;
    int t;
    t = 0;
    w_valid = 1'b1; w_data = stim_w[row];
    @(negedge clk);
    while (!w_ready && t < 20) begin t++; @(negedge clk); end
    ok = w_ready;
    if (ok) begin
      e = '0; e.en[row] = 1'b1; e.we[row] = 1'b1; e.dl = stim_w[row];
      sb_strobe.push_back(e);
      ref_w[row] = stim_w[row];
    end else begin
      vec++; errs++;
      $display("FAIL w_ready_timeout row %0d: got %0b, expected 1", row, w_ready);
    end
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic a_beat(input int row, input bit poke, output bit ok);
    strobe_t e;
    int t;
    t = 0;
    a_valid = 1'b1; a_data = stim_a[row]; a_data_n = stim_an[row];
    if (poke) begin cmd_start = 1'b1; cmd_mode = MODE_LOAD; cmd_rows = ROW_W'(1); end
    @(negedge clk);
    while (!a_ready && t < 20) begin t++; @(negedge clk); end
    ok = a_ready;
    if (ok) begin
      e = '0; e.en[row] = 1'b1; e.sel[row] = 1'b1; e.dl = stim_a[row]; e.dln = stim_an[row];
      sb_strobe.push_back(e);
    end else begin
      vec++; errs++;
      $display("FAIL a_ready_timeout row %0d: got %0b, expected 1", row, a_ready);
    end
    @(posedge clk); #1;
    a_valid = 1'b0; cmd_start = 1'b0;
  endtask

  task automatic do_load(input int rows, input bit gaps);
    int n;
    bit ok;
    n = (rows > NR) ? NR : rows;
    start_cmd(MODE_LOAD, rows);
    if (n == 0) begin
      check("load0_done", done, 1);
      check("load0_busy", busy, 0);
      check("load0_w_ready", w_ready, 0);
      @(posedge clk); #1;
      check("load0_done_pulse", done, 0);
      return;
    end
    check("load_w_ready", w_ready, 1);
    check("load_busy", busy, 1);
    for (int i = 0; i < n; i++) begin
      if (gaps) idle(int'($urandom_range(0, 2)));
      w_beat(i, ok);
      if (!ok) return;
    end
    check("load_w_ready_drop", w_ready, 0);
    check("load_done_early", done, 0);
    @(posedge clk); #1;
    check("load_done", done, 1);
    @(posedge clk); #1;
    check("load_done_pulse", done, 0);
    check("load_strobes_left", sb_strobe.size(), 0);
  endtask

  task automatic do_compute(input int rows, input bit gaps, input int hold, input bit poke);
    int n, t;
    bit ok;
    longint total;
    acc_exp_t x;
    logic [DW-1:0] wv, av;
    n = (rows > NR) ? NR : rows;
    total = 0;
    for (int i = 0; i < n; i++) begin
      wv = ref_w[i];
      av = wv[0] ? stim_an[i] : stim_a[i];
      total += longint'(wv[DW-1:1]) * longint'(av[DW-1:1]);
    end
`ifdef CIM_ROW_SCHED_SAT_EN
    x.data = (total > ACC_MAX) ? AW'(ACC_MAX) : AW'(total);
    x.sat  = (total > ACC_MAX);
`else
    x.data = AW'(total % (ACC_MAX + 1));
    x.sat  = 1'b0;
`endif
    sb_acc.push_back(x);
    start_cmd(MODE_COMPUTE, rows);
    if (n > 0) begin
      check("cmp_a_ready", a_ready, 1);
      for (int i = 0; i < n; i++) begin
        if (gaps) idle(int'($urandom_range(0, 2)));
        a_beat(i, poke && (i == 1), ok);
        if (!ok) return;
      end
      check("cmp_a_ready_drop", a_ready, 0);
      check("cmp_busy", busy, 1);
    end
    t = 0;
    while (!acc_valid && t < 40) begin @(posedge clk); #1; t++; end
    if (!acc_valid) begin
      vec++; errs++;
      $display("FAIL acc_valid_timeout: got 0, expected 1");
      return;
    end
    repeat (hold) begin
      check("out_no_done", done, 0);
      @(posedge clk); #1;
    end
    acc_ready = 1'b1;
    @(posedge clk); #1;
    acc_ready = 1'b0;
    check("out_done", done, 1);
    check("out_valid_drop", acc_valid, 0);
    check("out_idle", busy, 0);
    @(posedge clk); #1;
    check("out_done_pulse", done, 0);
    check("acc_left", sb_acc.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cell_en"}, cell_en, 0);
    check({tag, "_cell_we"}, cell_write_en, 0);
    check({tag, "_cell_sel"}, cell_sel, 0);
    check({tag, "_data_line"}, data_line, 0);
    check({tag, "_data_line_n"}, data_line_n, 0);
    check({tag, "_w_ready"}, w_ready, 0);
    check({tag, "_a_ready"}, a_ready, 0);
    check({tag, "_acc_valid"}, acc_valid, 0);
    check({tag, "_acc_data"}, acc_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic reset_mid_load();
    bit ok;
    for (int i = 0; i < 4; i++) stim_w[i] = DW'($urandom);
    start_cmd(MODE_LOAD, 4);
    w_beat(0, ok);
    w_beat(1, ok);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    sb_strobe.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy_after", busy, 0);
    check("midrst_w_ready_after", w_ready, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    cmd_start = 1'b0; cmd_mode = 1'b0; cmd_rows = '0;
    w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0; a_data_n = '0;
    acc_ready = 1'b0;
    for (int i = 0; i < NR; i++) begin
      stim_w[i] = '0; stim_a[i] = '0; stim_an[i] = '0; ref_w[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    stim_w[0] = 9'h0A2; stim_w[1] = 9'h1FF; stim_w[2] = 9'h003;
    do_load(3, 1'b0);

    stim_w[0] = 9'h00A; stim_w[1] = 9'h1FE; stim_w[2] = 9'h002;
    do_load(3, 1'b0);
    stim_a[0] = 9'h008; stim_a[1] = 9'h004; stim_a[2] = 9'h0C8;
    for (int i = 0; i < 3; i++) stim_an[i] = DW'($urandom);
    do_compute(3, 1'b0, 0, 1'b0);

    for (int i = 0; i < 3; i++) begin stim_a[i] = DW'($urandom); stim_an[i] = DW'($urandom); end
    do_compute(3, 1'b1, 5, 1'b0);

    do_load(0, 1'b0);
    do_compute(0, 1'b0, 2, 1'b0);

    do_compute(3, 1'b0, 1, 1'b1);

    reset_mid_load();

    for (int i = 0; i < NR; i++) begin
      stim_w[i] = DW'($urandom); stim_a[i] = DW'($urandom); stim_an[i] = DW'($urandom);
    end
    do_load(20, 1'b0);
    do_compute(20, 1'b0, 0, 1'b0);

    stim_w[0] = 9'h1FE; stim_w[1] = 9'h1FE;
    do_load(2, 1'b0);
    stim_a[0] = 9'h1FE; stim_a[1] = 9'h1FE;
    do_compute(2, 1'b0, 1, 1'b0);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NR; i++) begin
        stim_w[i] = DW'($urandom); stim_a[i] = DW'($urandom); stim_an[i] = DW'($urandom);
      end
      do_load(int'($urandom_range(1, NR)), 1'b1);
      do_compute(int'($urandom_range(1, NR + 3)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), 1'b0);
    end

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/cim_row_sched.md
Name: cim_row_sched

Overview:
- Sequencer for one column of NUM_ROWS cim_cell instances.
- Runs two command types:
  - LOAD: streams weight words (8-bit weight plus metadata LSB) into rows 0..N-1 via per-row en/write_en strobes.
  - COMPUTE: streams activations row by row with a one-hot sel, collects each registered cell product and returns the column sum on a valid/ready output.
- Sits between the layer controller (command and streams) and the cell column / adder tree.

Parameters:
- DATA_WIDTH, 9, cell word width: weight bits [DATA_WIDTH-1:1], metadata bit [0].
- NUM_ROWS, 16, number of cells in the column.
- ACC_WIDTH, 24, accumulator width; must be >= 2*(DATA_WIDTH-1).
- Derived localparams: ROW_W = $clog2(NUM_ROWS+1); PROD_W = 2*(DATA_WIDTH-1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_start  in  1  one-cycle command pulse.
- cmd_mode  in  1  0 = LOAD, 1 = COMPUTE; sampled with cmd_start.
- cmd_rows  in  ROW_W  rows to process; values above NUM_ROWS are clamped to NUM_ROWS.
- w_valid / w_ready  in / out  1  weight stream handshake.
- w_data  in  DATA_WIDTH  weight word.
- a_valid / a_ready  in / out  1  activation stream handshake.
- a_data  in  DATA_WIDTH  activation word.
- a_data_n  in  DATA_WIDTH  alternate activation word, selected in the cell when metadata = 1.
- cell_en  out  NUM_ROWS  per-row enable (one-hot or zero).
- cell_write_en  out  NUM_ROWS  per-row write strobe.
- cell_sel  out  NUM_ROWS  per-row compute select.
- data_line  out  DATA_WIDTH  broadcast line.
- data_line_n  out  DATA_WIDTH  broadcast alternate line.
- cell_valid  in  1  OR of all cell out_data_valid.
- cell_result  in  PROD_W  OR of all cell mac_result_out (non-selected cells drive 0).
- acc_valid / acc_ready  out / in  1  column-sum output handshake.
- acc_data  out  ACC_WIDTH  column sum.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (asynchronous): state IDLE, all counters and the accumulator cleared. Every output resets to 0, including w_ready, a_ready, acc_valid, busy and done.
- FSM states: IDLE, LOAD, COMPUTE, DRAIN, OUT.
- IDLE:
  - cmd_start moves the FSM to LOAD or COMPUTE according to cmd_mode.
  - On entry: row counter = 0, issued = 0, received = 0, accumulator cleared, N = min(cmd_rows, NUM_ROWS) latched.
  - N = 0 in LOAD: go to IDLE with done pulsed the next cycle; no cell is touched.
  - N = 0 in COMPUTE: go directly to OUT with acc_data = 0.
- cmd_start while busy is ignored; the latched command is unaffected.
- LOAD:
  - w_ready = 1.
  - A beat accepted at cycle t (w_valid & w_ready) drives, registered at t+1 for exactly one cycle: cell_en[row] = cell_write_en[row] = 1, data_line = w_data, data_line_n = 0.
  - The row counter increments on each accepted beat.
  - After the Nth beat: w_ready drops the same cycle the counter reaches N, the FSM returns to IDLE and done pulses on the cycle after the last strobe.
- COMPUTE:
  - a_ready = 1.
  - A beat accepted at cycle t drives at t+1 for one cycle: cell_en[row] = cell_sel[row] = 1, data_line = a_data, data_line_n = a_data_n; issued increments.
  - The cell returns cell_valid at t+2.
  - Back-to-back beats are allowed, one row per cycle.
  - After the Nth beat the FSM moves to DRAIN.
- Accumulation (any of COMPUTE or DRAIN):
  - When cell_valid = 1: acc += zero-extended cell_result (unsigned, wraps modulo 2^ACC_WIDTH by default); received increments.
  - cell_valid in IDLE, LOAD or OUT is ignored.
- DRAIN:
  - Stays until received == N, then moves to OUT.
  - A result arriving in the same cycle as the DRAIN-to-OUT check is counted before the comparison.
- OUT:
  - acc_valid = 1 and acc_data is held stable until acc_ready.
  - On the handshake: acc_valid drops, done pulses for 1 cycle, FSM returns to IDLE.
- Outside active strobes: cell_en, cell_write_en and cell_sel are 0; data_line and data_line_n hold their last values.
- At most one bit of cell_en is set in any cycle.
- Reset asserted mid-command: immediate return to IDLE with all outputs 0; any partial load is the layer controller's responsibility to redo.

Optional Feature:
- Macro CIM_ROW_SCHED_SAT_EN.
- Defined: the accumulator saturates at 2^ACC_WIDTH-1 on overflow, and the sticky output acc_sat (1 bit, cleared at command start) is added.
- Undefined: the accumulator wraps and the acc_sat port does not exist.

Decomposition:
- Package cim_pkg:
  - FSM state enum.
  - Mode constants MODE_LOAD = 1'b0 and MODE_COMPUTE = 1'b1.
  - PROD_W helper function.
- One natural sub-module, cim_col_acc: clear, add-on-valid, received counter and the optional saturation logic.

Test Plan:
- LOAD N=3 with w_data 0x0A2, 0x1FF, 0x003 -> cell_en/cell_write_en one-hot 001, 010, 100 on consecutive cycles; data_line matches each word; done 1 cycle after the last strobe.
- COMPUTE N=3, cell model weights {5, 255, 1}, a_data {4, 2, 100} -> acc_data = 20 + 510 + 100 = 630, acc_valid asserted after the last result.
- COMPUTE with a_valid gaps and acc_ready held low 5 cycles -> acc_data stable, done only after the acc_ready handshake.
- cmd_rows = 0 (LOAD) -> done next cycle, no strobes; cmd_rows = 0 (COMPUTE) -> acc_data = 0 presented; cmd_rows = 20 with NUM_ROWS = 16 -> exactly 16 rows processed.
- cmd_start during COMPUTE and rst_n low mid-LOAD -> the second start is ignored; reset forces all outputs to 0 and state IDLE.
- CIM_ROW_SCHED_SAT_EN with ACC_WIDTH = 16 and two products of 65025 -> acc_data = 0xFFFF and acc_sat = 1; without the macro -> acc_data = 0xFC02.
